multichannel_dds_core: RTL

Parametrised, time-multiplexed direct digital synthesis core that generates CHANNELS independent waveforms through one shared three-stage pipeline. It replaces the single-channel accumulator / shaper / amplitude chain between the control unit and the SPI DAC driver. Each channel has its own tuning word, phase offset, shape and amplitude. All channels update coherently on a sample tick, typically the 1 MHz sample strobe. Outputs are one tagged sample stream consumed by the DAC driver(s).

---
 rtl/multichannel_dds_core.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/multichannel_dds_core.sv
`default_nettype none
// ============================================================================
//  Module   : multichannel_dds_core
//  Purpose  : Time-multiplexed DDS; CHANNELS waveforms share one 3-stage pipe.
//  Revision : 1.0  initial release
// ============================================================================
module multichannel_dds_core #(
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 12,
    parameter int AMP_W    = 11,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_addr,
    input  logic [ACC_W-1:0]  cfg_wdata,
    input  logic              sample_tick,
    input  logic              sync,
    output logic              busy,
    output logic              overrun,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [OUT_W-1:0]  out_data
);

    localparam logic [CH_W-1:0]  c_last = CH_W'(CHANNELS - 1);
    localparam logic [OUT_W-1:0] c_mid  = {1'b1, {(OUT_W-1){1'b0}}};

    logic [ACC_W-1:0] r_m_sh     [CHANNELS];
    logic [ACC_W-1:0] r_off_sh   [CHANNELS];
    logic [1:0]       r_shape_sh [CHANNELS];
    logic [AMP_W-1:0] r_amp_sh   [CHANNELS];
    logic [ACC_W-1:0] r_m_act    [CHANNELS];
    logic [ACC_W-1:0] r_off_act  [CHANNELS];
    logic [1:0]       r_shape_act[CHANNELS];
    logic [AMP_W-1:0] r_amp_act  [CHANNELS];
    logic [ACC_W-1:0] r_acc      [CHANNELS];

    logic             r_issuing, r_sweep_zero, r_sync_pend;
    logic [CH_W-1:0]  r_issue_ch;
    logic             w_tick_ok, w_cfg_hit, w_issuing_nx;
    logic [CH_W-1:0]  w_issue_ch_nx;

    logic             r_s1_valid, r_s2_valid;
    logic [CH_W-1:0]  r_s1_ch, r_s2_ch;
    logic [OUT_W:0]   r_s1_phase;
    logic [1:0]       r_s1_shape;
    logic [AMP_W-1:0] r_s1_amp, r_s2_amp;
    logic [OUT_W-1:0] r_s2_raw, w_raw;
    logic [ACC_W-1:0] w_acc_cur, w_phase;

    logic signed [OUT_W:0]         w_s;
    logic signed [OUT_W+AMP_W+1:0] w_prod, w_scaled;
    logic [OUT_W-1:0]              w_out;
    logic                          w_unused;

    assign w_tick_ok = sample_tick & ~busy;
    assign w_cfg_hit = cfg_we && (int'(cfg_ch) < CHANNELS);

    // Shadow bank: host writes only ever land here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_m_sh[k]     <= '0;
                r_off_sh[k]   <= '0;
                r_shape_sh[k] <= 2'd3;
                r_amp_sh[k]   <= '0;
            end
        end else if (w_cfg_hit) begin
            case (cfg_addr)
                2'd0:    r_m_sh[cfg_ch]     <= cfg_wdata;
                2'd1:    r_off_sh[cfg_ch]   <= cfg_wdata;
                2'd2:    r_shape_sh[cfg_ch] <= cfg_wdata[1:0];
                default: r_amp_sh[cfg_ch]   <= cfg_wdata[AMP_W-1:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_m_act[k]     <= '0;
                r_off_act[k]   <= '0;
                r_shape_act[k] <= 2'd3;
                r_amp_act[k]   <= '0;
            end
        end else if (w_tick_ok) begin
            r_m_act     <= r_m_sh;
            r_off_act   <= r_off_sh;
            r_shape_act <= r_shape_sh;
            r_amp_act   <= r_amp_sh;
        end
    end

    // An accepted tick may restart issue on the same edge the last channel goes out.
    always_comb begin
        w_issuing_nx  = r_issuing;
        w_issue_ch_nx = r_issue_ch;
        if (w_tick_ok) begin
            w_issuing_nx  = 1'b1;
            w_issue_ch_nx = '0;
        end else if (r_issuing) begin
            if (r_issue_ch == c_last) w_issuing_nx = 1'b0;
            else                      w_issue_ch_nx = r_issue_ch + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issuing    <= 1'b0;
            r_issue_ch   <= '0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            r_sweep_zero <= 1'b0;
            r_sync_pend  <= 1'b0;
        end else begin
            r_issuing  <= w_issuing_nx;
            r_issue_ch <= w_issue_ch_nx;
            busy       <= w_issuing_nx && (w_issue_ch_nx != c_last);
            overrun    <= sample_tick & busy;
            if (w_tick_ok) begin
                r_sweep_zero <= r_sync_pend | sync;
                r_sync_pend  <= 1'b0;
            end else if (sync) begin
                r_sync_pend  <= 1'b1;
            end
        end
    end

    assign w_acc_cur = r_sweep_zero ? '0 : r_acc[r_issue_ch];
    assign w_phase   = w_acc_cur + r_off_act[r_issue_ch];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) r_acc[k] <= '0;
            r_s1_valid <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_phase <= '0;
            r_s1_shape <= '0;
            r_s1_amp   <= '0;
        end else begin
            r_s1_valid <= r_issuing;
            if (r_issuing) begin
                r_acc[r_issue_ch] <= w_acc_cur + r_m_act[r_issue_ch];
                r_s1_ch    <= r_issue_ch;
                r_s1_phase <= w_phase[ACC_W-1 -: OUT_W+1];
                r_s1_shape <= r_shape_act[r_issue_ch];
                r_s1_amp   <= r_amp_act[r_issue_ch];
            end
        end
    end

    always_comb begin
        w_raw = c_mid;
        case (r_s1_shape)
            2'd0:    w_raw = r_s1_phase[OUT_W] ? '0 : '1;
            2'd1:    w_raw = r_s1_phase[OUT_W -: OUT_W];
            2'd2:    w_raw = r_s1_phase[OUT_W] ? ~r_s1_phase[OUT_W-1:0] : r_s1_phase[OUT_W-1:0];
            default: w_raw = c_mid;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_ch    <= '0;
            r_s2_raw   <= '0;
            r_s2_amp   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_ch  <= r_s1_ch;
                r_s2_raw <= w_raw;
                r_s2_amp <= r_s1_amp;
            end
        end
    end

    // Scaled result always fits OUT_W, so the upper product bits are discarded.
    assign w_s      = $signed({1'b0, r_s2_raw}) - $signed({2'b01, {(OUT_W-1){1'b0}}});
    assign w_prod   = w_s * $signed({1'b0, r_s2_amp});
    assign w_scaled = w_prod >>> AMP_W;
    assign w_out    = w_scaled[OUT_W-1:0] + c_mid;
    assign w_unused = ^{w_phase, w_scaled};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                out_ch   <= r_s2_ch;
                out_data <= w_out;
            end
        end
    end

endmodule
`default_nettype wire
